// File: rtl/debounce_event_multi_pkg.sv
// Shared helpers for the multi-channel debouncer: constant width computation.
package debounce_event_multi_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_event_multi_chan.sv
// One debounced channel: 2-flop synchroniser, N-sample stable filter,
// rise/fall pulses and a saturating long-press hold counter.
module debounce_event_chan
  import debounce_event_multi_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned LONG_CNT = 1000,
  parameter bit          INIT     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  input  logic tick_i,
  output logic out_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_press_o
);

  localparam int unsigned HW = clog2(LONG_CNT + 1);

  logic          sync1_q, sync2_q;
  logic [N-1:0]  shift_q, shift_d;
  logic          out_q, out_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          long_q, long_d;
  logic [HW-1:0] hold_q, hold_d;

  always_comb begin
    shift_d = shift_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (tick_i) begin
      shift_d = {shift_q[N-2:0], sync2_q};
      if ((&shift_d) && !out_q) begin
        out_d  = 1'b1;
        rise_d = 1'b1;
      end else if (!(|shift_d) && out_q) begin
        out_d  = 1'b0;
        fall_d = 1'b1;
      end
    end
  end

  // Counting only while out was already high keeps the rise tick from
  // counting, so long_press lands exactly LONG_CNT ticks after rise.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (!out_d) begin
      hold_d = '0;
    end else if (out_q && tick_i && (hold_q != HW'(LONG_CNT))) begin
      hold_d = hold_q + HW'(1);
      long_d = (hold_q == HW'(LONG_CNT - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= INIT;
      sync2_q <= INIT;
      shift_q <= {N{INIT}};
      out_q   <= INIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      long_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      sync1_q <= in_i;
      sync2_q <= sync1_q;
      shift_q <= shift_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      long_q  <= long_d;
      hold_q  <= hold_d;
    end
  end

  assign out_o        = out_q;
  assign rise_o       = rise_q;
  assign fall_o       = fall_q;
  assign long_press_o = long_q;

endmodule

// File: rtl/debounce_event_multi.sv
// Multi-channel debouncer top: one shared sample prescaler feeding WIDTH
// independent debounce/event channels.
module debounce_event_multi
  import debounce_event_multi_pkg::*;
#(
  parameter int unsigned      WIDTH    = 9,
  parameter int unsigned      N        = 4,
  parameter int unsigned      RATE     = 125000,
  parameter int unsigned      LONG_CNT = 1000,
  parameter logic [WIDTH-1:0] INIT     = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] long_press,
  output logic             tick
);

  localparam int unsigned CW = (RATE > 1) ? clog2(RATE) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    tick_d = (cnt_q == CW'(RATE - 1));
    cnt_d  = tick_d ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_event_chan #(
      .N        (N),
      .LONG_CNT (LONG_CNT),
      .INIT     (INIT[i])
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_i         (in[i]),
      .tick_i       (tick_q),
      .out_o        (out[i]),
      .rise_o       (rise[i]),
      .fall_o       (fall[i]),
      .long_press_o (long_press[i])
    );
  end

endmodule
